pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on posedge clk.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  level; begins a run from IDLE.
REQ-004 SHALL have port: pc_en  input  1  from decoder; PC update permitted this step.
REQ-005 SHALL have port: pc_inc0_jum1  input  1  0 = PC+pc_ext (relative or increment), 1 = load pc_ext.
REQ-006 SHALL have port: pc_ext  input  16  offset (two's complement) or absolute target.
REQ-007 SHALL have port: done  input  1  HLT decoded.
REQ-008 SHALL have ports: imem_req output 1, imem_addr output 8, imem_rdata input 16, imem_rvalid input 1; instruction memory read.
REQ-009 SHALL have ports: instruction output 16, pc_addr output 16, step output 1, halted output 1, busy output 1.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, ISSUE, STEP, HALT.
REQ-011 IDLE: start=1 -> REQ next cycle; otherwise hold.
REQ-012 REQ: imem_req=1 for exactly one cycle, imem_addr=pc_addr[7:0]; -> WAIT.
REQ-013 WAIT: imem_rvalid=1 -> capture imem_rdata into instruction, -> ISSUE; rvalid outside WAIT SHALL be ignored.
REQ-014 ISSUE: instruction held stable one cycle so the decoder's registered copy is valid; -> STEP.
REQ-015 STEP: step=1 for exactly one cycle; instruction unchanged.
REQ-016 At end of STEP with done=1: -> HALT, PC unchanged, regardless of pc_en.
REQ-017 At end of STEP with done=0 and pc_en=1: PC <= pc_inc0_jum1 ? pc_ext : PC + pc_ext; -> REQ.
REQ-018 At end of STEP with done=0 and pc_en=0: PC unchanged; -> REQ (refetch same address).
REQ-019 PC arithmetic SHALL be 16-bit modulo 2^16 (0xFFFF + 1 = 0x0000; 0x0000 + 0xFFFF = 0xFFFF).
REQ-020 imem_addr SHALL be PC[7:0]; PC[15:8] SHALL be ignored for memory access.
REQ-021 HALT: halted=1; leave only via reset; start ignored.
REQ-022 busy=1 in REQ, WAIT, ISSUE, STEP; start SHALL be ignored while busy.
REQ-023 Fetch latency: step asserts no earlier than 3 cycles after imem_req; unbounded wait on rvalid permitted.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, PC=0x0000, instruction=0x0000, imem_req=0, imem_addr=0x00, step=0, halted=0, busy=0.
REQ-025 Reset mid-fetch SHALL abandon the outstanding read; a late imem_rvalid after release SHALL be ignored (FSM in IDLE).

Configuration
REQ-026 Macro PC_FETCH_ICOUNT_EN: when defined, SHALL add output icount[15:0], reset 0, incremented (wrapping) on each STEP with done=0; when undefined, port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-027 FSM state encoding, PC width (16) and IMEM address width (8) SHALL live in the shared CPU package.
REQ-028 Next-PC computation SHALL be a combinational sub-module pc_next_calc (inputs PC, pc_ext, pc_inc0_jum1; output next PC).

Verification
REQ-029 Reset, start=1, rvalid one cycle after req with 0x0800, pc_en=1, jum=0, pc_ext=0x0001 -> imem_addr 0x00 then 0x01; step one cycle; PC=0x0001.
REQ-030 Branch back: PC=0x0010, pc_ext=0xFFFC, jum=0 -> next imem_addr 0x0C, PC=0x000C.
REQ-031 Jump: PC=0x0005, jum=1, pc_ext=0x8123 -> PC=0x8123, imem_addr=0x23.
REQ-032 Wrap: PC=0xFFFF, pc_ext=0x0001, jum=0 -> PC=0x0000.
REQ-033 HLT: done=1 during STEP with pc_en=1 -> halted=1, PC unchanged, no further imem_req; start pulses ignored.
REQ-034 rvalid delayed 5 cycles, then rst_n pulsed during WAIT -> all outputs zero, state IDLE; stray rvalid after release has no effect.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg -- shared CPU package for the fetch front end.
// Holds the fetch FSM state encoding and the PC / IMEM address widths.
package pc_fetch_unit_pkg;

  localparam int PC_W    = 16;
  localparam int IMEM_AW = 8;
  localparam int INSN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_STEP  = 3'd4,
    ST_HALT  = 3'd5
  } fetch_state_e;

  // Busy covers the whole fetch/execute loop.
  function automatic logic is_busy(input fetch_state_e s);
    return (s == ST_REQ) || (s == ST_WAIT) || (s == ST_ISSUE) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc -- combinational next-PC.
// Ports:
//   pc           current PC
//   pc_ext       two's-complement offset (jum=0) or absolute target (jum=1)
//   pc_inc0_jum1 0 = pc + pc_ext, 1 = pc_ext
//   pc_nxt       next PC, modulo 2^16
module pc_next_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] pc_ext,
  input  logic            pc_inc0_jum1,
  output logic [PC_W-1:0] pc_nxt
);

  // Adding the offset at full width gives natural 16-bit wrap for
  // both forward increments and backward (negative) branches.
  assign pc_nxt = pc_inc0_jum1 ? pc_ext : PC_W'(pc + pc_ext);

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- PC register and instruction fetch sequencer.
// Loop: IDLE -> REQ -> WAIT -> ISSUE -> STEP -> (REQ | HALT).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               level, begins a run from IDLE
//   pc_en, pc_inc0_jum1, pc_ext, done   decoder controls sampled at end of STEP
//   imem_req/addr/rdata/rvalid          instruction memory read
//   instruction         fetched word, stable from ISSUE through STEP
//   pc_addr             current PC
//   step                one-cycle execute strobe
//   halted, busy        status
// Optional: define PC_FETCH_ICOUNT_EN to add icount[15:0], the number of
// non-halting STEPs retired (wrapping).
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pc_en,
  input  logic               pc_inc0_jum1,
  input  logic [PC_W-1:0]    pc_ext,
  input  logic               done,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSN_W-1:0]  imem_rdata,
  input  logic               imem_rvalid,
  output logic [INSN_W-1:0]  instruction,
  output logic [PC_W-1:0]    pc_addr,
  output logic               step,
  output logic               halted,
  output logic               busy
`ifdef PC_FETCH_ICOUNT_EN
  ,
  output logic [15:0]        icount
`endif
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_tgt;

  pc_next_calc u_pc_next_calc (
    .pc           (pc_addr),
    .pc_ext       (pc_ext),
    .pc_inc0_jum1 (pc_inc0_jum1),
    .pc_nxt       (pc_nxt)
  );

  // With pc_en low the same address is simply refetched.
  assign pc_tgt = pc_en ? pc_nxt : pc_addr;

  // All outputs are registered and updated on the transition into the
  // state that owns them, so imem_req / step are clean one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc_addr     <= '0;
      instruction <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      step        <= 1'b0;
      halted      <= 1'b0;
      busy        <= 1'b0;
`ifdef PC_FETCH_ICOUNT_EN
      icount      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_addr[IMEM_AW-1:0];
            busy      <= 1'b1;
          end
        end
        ST_REQ: begin
          state    <= ST_WAIT;
          imem_req <= 1'b0;
        end
        ST_WAIT: begin
          // rvalid is only honoured here; stray beats elsewhere are dropped.
          if (imem_rvalid) begin
            instruction <= imem_rdata;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // One settle cycle so the decoder's registered copy is valid.
          state <= ST_STEP;
          step  <= 1'b1;
        end
        ST_STEP: begin
          step <= 1'b0;
          if (done) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state     <= ST_REQ;
            pc_addr   <= pc_tgt;
            imem_req  <= 1'b1;
            imem_addr <= pc_tgt[IMEM_AW-1:0];
`ifdef PC_FETCH_ICOUNT_EN
            icount    <= icount + 16'd1;
`endif
          end
        end
        ST_HALT: begin
          // Sticky until reset.
          halted <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
          step     <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pc_en = 1'b0;
  logic        pc_inc0_jum1 = 1'b0;
  logic [15:0] pc_ext = '0;
  logic        done = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] instruction;
  logic [15:0] pc_addr;
  logic        step;
  logic        halted;
  logic        busy;
`ifdef PC_FETCH_ICOUNT_EN
  logic [15:0] icount;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: architectural PC and retired-step count.
  logic [15:0] m_pc;
  logic [15:0] m_icount;
  logic        m_halted;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pc_en        (pc_en),
    .pc_inc0_jum1 (pc_inc0_jum1),
    .pc_ext       (pc_ext),
    .done         (done),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_rvalid  (imem_rvalid),
    .instruction  (instruction),
    .pc_addr      (pc_addr),
    .step         (step),
    .halted       (halted),
    .busy         (busy)
`ifdef PC_FETCH_ICOUNT_EN
    ,
    .icount       (icount)
`endif
  );

  // Reset the DUT and model, then kick off a run with start.
  task automatic reset_and_start();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; imem_rvalid = 1'b0; done = 1'b0; pc_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 16'h0000; m_icount = 16'h0000; m_halted = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full fetch/step transaction, checked against the model.
  task automatic do_fetch(input logic [15:0] rdata, input int dly,
                          input logic en, input logic jum,
                          input logic [15:0] ext, input logic dn,
                          input string tag);
    int n;
    int lat;
    n = 0;
    while (imem_req !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    total++;
    if (imem_req !== 1'b1) begin
      bad++; $display("FAIL %s req_timeout: imem_req=%b required 1", tag, imem_req);
      return;
    end
    total++;
    if (imem_addr !== m_pc[7:0] || pc_addr !== m_pc) begin
      bad++;
      $display("FAIL %s fetch_addr: imem_addr=%h pc_addr=%h required %h/%h",
               tag, imem_addr, pc_addr, m_pc[7:0], m_pc);
    end
    lat = 0;
    @(negedge clk); lat++;
    total++;
    if (imem_req !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL %s req_pulse: imem_req=%b busy=%b required 0/1", tag, imem_req, busy);
    end
    repeat (dly) begin @(negedge clk); lat++; end
    imem_rvalid = 1'b1; imem_rdata = rdata;
    @(negedge clk); lat++;
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    n = 0;
    while (step !== 1'b1 && n < 10) begin @(negedge clk); lat++; n++; end
    total++;
    if (step !== 1'b1 || lat < 3) begin
      bad++; $display("FAIL %s step_latency: step=%b lat=%0d required 1 and >=3", tag, step, lat);
      return;
    end
    total++;
    if (instruction !== rdata) begin
      bad++; $display("FAIL %s instruction: got %h required %h", tag, instruction, rdata);
    end
    pc_en = en; pc_inc0_jum1 = jum; pc_ext = ext; done = dn;
    @(negedge clk);
    pc_en = 1'b0; pc_inc0_jum1 = 1'b0; pc_ext = $urandom; done = 1'b0;
    if (dn) m_halted = 1'b1;
    else begin
      m_icount = m_icount + 16'd1;
      if (en) m_pc = jum ? ext : 16'((32'(m_pc) + 32'(ext)) % 32'h10000);
    end
    total++;
    if (step !== 1'b0 || instruction !== rdata || pc_addr !== m_pc || halted !== m_halted) begin
      bad++;
      $display("FAIL %s post_step: step=%b insn=%h pc=%h halted=%b required 0/%h/%h/%b",
               tag, step, instruction, pc_addr, halted, rdata, m_pc, m_halted);
    end
`ifdef PC_FETCH_ICOUNT_EN
    total++;
    if (icount !== m_icount) begin
      bad++; $display("FAIL %s icount: got %0d required %0d", tag, icount, m_icount);
    end
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr, instruction, pc_addr, step, halted, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req=%b addr=%h insn=%h pc=%h step=%b halted=%b busy=%b required all 0",
               imem_req, imem_addr, instruction, pc_addr, step, halted, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (imem_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_hold: req=%b busy=%b required 0/0", imem_req, busy);
    end
  endtask

  task automatic test_basic();
    reset_and_start();
    do_fetch(16'h0800, 0, 1'b1, 1'b0, 16'h0001, 1'b0, "basic0");
    total++;
    if (imem_addr !== 8'h01 || pc_addr !== 16'h0001) begin
      bad++; $display("FAIL basic_pc: addr=%h pc=%h required 01/0001", imem_addr, pc_addr);
    end
    do_fetch(16'h1234, 2, 1'b0, 1'b0, 16'h0007, 1'b0, "no_en");
  endtask

  task automatic test_branch_jump_wrap();
    reset_and_start();
    do_fetch(16'h0001, 1, 1'b1, 1'b1, 16'h0010, 1'b0, "to10");
    do_fetch(16'h0002, 0, 1'b1, 1'b0, 16'hFFFC, 1'b0, "branch_back");
    total++;
    if (imem_addr !== 8'h0C || pc_addr !== 16'h000C) begin
      bad++; $display("FAIL branch_back: addr=%h pc=%h required 0C/000C", imem_addr, pc_addr);
    end
    do_fetch(16'h0003, 0, 1'b1, 1'b1, 16'h0005, 1'b0, "to05");
    do_fetch(16'h0004, 3, 1'b1, 1'b1, 16'h8123, 1'b0, "jump");
    total++;
    if (imem_addr !== 8'h23 || pc_addr !== 16'h8123) begin
      bad++; $display("FAIL jump: addr=%h pc=%h required 23/8123", imem_addr, pc_addr);
    end
    do_fetch(16'h0005, 0, 1'b1, 1'b1, 16'hFFFF, 1'b0, "toFFFF");
    do_fetch(16'h0006, 0, 1'b1, 1'b0, 16'h0001, 1'b0, "wrap");
    total++;
    if (imem_addr !== 8'h00 || pc_addr !== 16'h0000) begin
      bad++; $display("FAIL wrap: addr=%h pc=%h required 00/0000", imem_addr, pc_addr);
    end
    do_fetch(16'h0007, 0, 1'b1, 1'b0, 16'hFFFF, 1'b0, "wrap_neg");
  endtask

  task automatic test_random();
    reset_and_start();
    for (int i = 0; i < 40; i++) begin
      do_fetch(16'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) != 0),
               1'($urandom), 16'($urandom), 1'b0, "random");
    end
  endtask

  task automatic test_halt();
    int reqs;
    reset_and_start();
    do_fetch(16'hAAAA, 0, 1'b1, 1'b0, 16'h0003, 1'b0, "pre_halt");
    do_fetch(16'hF000, 1, 1'b1, 1'b1, 16'h4444, 1'b1, "halt");
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      start = 1'(i % 2);
      @(negedge clk);
      if (imem_req === 1'b1) reqs++;
    end
    start = 1'b0;
    total++;
    if (reqs != 0 || halted !== 1'b1 || busy !== 1'b0 || pc_addr !== 16'h0003) begin
      bad++;
      $display("FAIL halt_hold: reqs=%0d halted=%b busy=%b pc=%h required 0/1/0/0003",
               reqs, halted, busy, pc_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int reqs;
    reset_and_start();
    do_fetch(16'h0101, 0, 1'b1, 1'b1, 16'h0042, 1'b0, "pre_abort");
    repeat (5) @(negedge clk);   // in WAIT, rvalid withheld
    rst_n = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr, instruction, pc_addr, step, halted, busy} !== '0) begin
      bad++;
      $display("FAIL mid_reset: req=%b addr=%h insn=%h pc=%h step=%b halted=%b busy=%b required all 0",
               imem_req, imem_addr, instruction, pc_addr, step, halted, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 16'hDEAD;
    @(negedge clk);
    imem_rvalid = 1'b0;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 || step === 1'b1 || busy === 1'b1) reqs++;
    end
    total++;
    if (reqs != 0 || instruction !== 16'h0000 || pc_addr !== 16'h0000) begin
      bad++;
      $display("FAIL stray_rvalid: activity=%0d insn=%h pc=%h required 0/0000/0000",
               reqs, instruction, pc_addr);
    end
  endtask

  initial begin
    m_pc = '0; m_icount = '0; m_halted = 1'b0;
    test_reset();
    test_basic();
    test_branch_jump_wrap();
    test_random();
    test_halt();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
